// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT with memory wait timeout.
// Optional macro ADDI_OVF_TRAP_EN: addi overflow writes constant 1 to $30 instead of the ALU result.
module multicycle_controller #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  input  logic       positive,
  input  logic       mem_ready,
  output logic [1:0] alu_ctl,
  output logic       ext_op,
  output logic       alu_src,
  output logic [2:0] reg_src,
  output logic [1:0] reg_dst,
  output logic       npc_sel,
  output logic       j_ctl,
  output logic       jr_ctl,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [2:0] state,
  output logic       err
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic rtype, is_addu, is_subu, is_slt, is_jr, is_ori, is_beq, is_j, is_jal;
  logic is_lw, is_sw, is_lui, is_addi, is_addiu, is_alu, illegal, addi_trap;
  logic timed_out, waiting;
  logic pc_write_c, ir_write_c, mem_read_c, mem_write_c, reg_write_c;

  assign rtype    = (opcode == 6'h00);
  assign is_addu  = rtype && (funct == 6'h21);
  assign is_subu  = rtype && (funct == 6'h23);
  assign is_slt   = rtype && (funct == 6'h2A);
  assign is_jr    = rtype && (funct == 6'h08);
  assign is_ori   = (opcode == 6'h0D);
  assign is_beq   = (opcode == 6'h04);
  assign is_j     = (opcode == 6'h02);
  assign is_jal   = (opcode == 6'h03);
  assign is_lw    = (opcode == 6'h23);
  assign is_sw    = (opcode == 6'h2B);
  assign is_lui   = (opcode == 6'h0F);
  assign is_addi  = (opcode == 6'h08);
  assign is_addiu = (opcode == 6'h09);
  assign is_alu   = is_addu | is_subu | is_slt | is_ori | is_lui | is_addi | is_addiu;
  assign illegal  = ~(is_alu | is_jr | is_beq | is_j | is_jal | is_lw | is_sw);

`ifdef ADDI_OVF_TRAP_EN
  assign addi_trap = is_addi & overflow;
`else
  logic unused_overflow;
  assign unused_overflow = overflow;
  assign addi_trap       = 1'b0;
`endif

  // Datapath selects follow the instruction fields in every state; next-PC selects
  // are held off in FETCH so the PC+4 update is never redirected.
  always_comb begin
    alu_ctl = 2'b00;
    if (is_subu || is_slt || is_beq) alu_ctl = 2'b01;
    else if (is_ori)                 alu_ctl = 2'b10;
    else if (is_lui)                 alu_ctl = 2'b11;
    ext_op  = is_addi | is_addiu | is_lw | is_sw | is_beq;
    alu_src = is_ori | is_lui | is_addi | is_addiu | is_lw | is_sw;
    reg_src = 3'b000;
    if (is_lw)          reg_src = 3'b001;
    else if (is_slt)    reg_src = positive ? 3'b010 : 3'b011;
    else if (is_jal)    reg_src = 3'b100;
    else if (addi_trap) reg_src = 3'b011;
    reg_dst = 2'b00;
    if (is_addu || is_subu || is_slt) reg_dst = 2'b01;
    else if (is_jal)                  reg_dst = 2'b11;
    else if (addi_trap)               reg_dst = 2'b10;
    npc_sel = (state_q != S_FETCH) && is_beq;
    j_ctl   = (state_q != S_FETCH) && (is_j || is_jal);
    jr_ctl  = (state_q != S_FETCH) && is_jr;
  end

  assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));
  assign waiting   = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_c = 1'b1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end else if (timed_out) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end
      end
      S_DECODE: begin
        if (illegal) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        if (is_alu)                state_d = S_WB;
        else if (is_lw || is_sw)   state_d = S_MEM;
        else if (is_beq)           pc_write_c = zero;
        else if (is_j || is_jr)    pc_write_c = 1'b1;
        else if (is_jal) begin
          pc_write_c  = 1'b1;
          reg_write_c = 1'b1;
        end
      end
      S_MEM: begin
        mem_read_c  = is_lw;
        mem_write_c = ~is_lw;
        if (mem_ready) begin
          state_d = is_lw ? S_WB : S_FETCH;
        end else if (timed_out) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end
      end
      S_WB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_HALT: err_d = 1'b1;
      default: begin
        state_d = S_HALT;
        err_d   = 1'b1;
      end
    endcase
    // Any state change clears the counter, which covers every entry into FETCH/MEM.
    if (state_d != state_q) cnt_d = '0;
    else if (waiting)       cnt_d = cnt_q + 1'b1;
    else                    cnt_d = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign pc_write  = pc_write_c  & ~rst;
  assign ir_write  = ir_write_c  & ~rst;
  assign mem_read  = mem_read_c  & ~rst;
  assign mem_write = mem_write_c & ~rst;
  assign reg_write = reg_write_c & ~rst;
  assign state     = state_q;
  assign err       = err_q;

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: max cycles to wait for mem_ready in FETCH/MEM; 0 disables the timeout.
REQ-002 SHALL have parameter CNT_W, default 4: wait-counter width; TIMEOUT SHALL fit in CNT_W bits.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports opcode  in  6 and funct  in  6  instruction fields from the instruction register.
REQ-006 SHALL have ports zero, overflow, positive  in  1 each  ALU flags.
REQ-007 SHALL have port mem_ready  in  1  memory handshake completion.
REQ-008 SHALL have ports alu_ctl  out  2 (00 addu, 01 subu, 10 or, 11 lui), ext_op  out  1, alu_src  out  1.
REQ-009 SHALL have ports reg_src  out  3 (000 alu, 001 mem, 010 const 0, 011 const 1, 100 link PC) and reg_dst  out  2 (00 rt, 01 rd, 10 $30, 11 $31).
REQ-010 SHALL have ports npc_sel, j_ctl, jr_ctl  out  1 each  next-PC selects.
REQ-011 SHALL have strobes pc_write, ir_write, mem_read, mem_write, reg_write  out  1 each.
REQ-012 SHALL have ports state  out  3 (current state) and err  out  1 (sticky fault).

Function
REQ-013 SHALL decode addu, subu, slt, jr (opcode 0 with funct 21h/23h/2Ah/08h) and ori 0Dh, beq 04h, j 02h, jal 03h, lw 23h, sw 2Bh, lui 0Fh, addi 08h, addiu 09h; anything else is illegal.
REQ-014 SHALL drive the mux selects (alu_ctl, ext_op, alu_src, reg_src, reg_dst, npc_sel, j_ctl, jr_ctl) combinationally from opcode/funct/flags in every state; the strobes alone gate any effect.
REQ-015 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
REQ-016 FETCH: SHALL assert mem_read; when mem_ready=1, SHALL assert ir_write and pc_write with npc_sel=0 for that cycle, then go to DECODE.
REQ-017 DECODE: illegal instruction SHALL go to HALT and set err; otherwise SHALL go to EXEC next cycle.
REQ-018 EXEC, ALU ops (addu, subu, slt, ori, lui, addi, addiu): SHALL go to WB; lw/sw SHALL go to MEM.
REQ-019 EXEC, beq: SHALL assert pc_write only if zero=1, then go to FETCH.
REQ-020 EXEC, j/jr: SHALL assert pc_write, then go to FETCH.
REQ-021 EXEC, jal: SHALL assert pc_write and reg_write with reg_src=100 and reg_dst=11 in the same cycle, then go to FETCH.
REQ-022 MEM, lw: SHALL assert mem_read until mem_ready, then go to WB with reg_src=001.
REQ-023 MEM, sw: SHALL assert mem_write until mem_ready, then go to FETCH.
REQ-024 WB: SHALL assert reg_write for exactly one cycle, then go to FETCH.
REQ-025 slt: reg_src SHALL be 011 when positive=0, else 010; reg_dst SHALL be 01.
REQ-026 Wait counter: SHALL clear on entry to FETCH/MEM and increment each waiting cycle without mem_ready.
REQ-027 Timeout: with TIMEOUT>0, if the counter equals TIMEOUT while mem_ready=0, SHALL go to HALT and set err; mem_ready arriving in that same cycle SHALL take priority.
REQ-028 HALT: all strobes SHALL be 0, and state SHALL remain HALT with err=1 until rst.
REQ-029 Latency: ALU op takes 4 cycles, lw 5, sw 4, beq/j/jr/jal 3, each with zero-wait memory.

Reset
REQ-030 When rst=1 at a clock edge, SHALL force state=FETCH, err=0, counter=0 and all strobes to 0, regardless of current state (including mid-MEM or HALT).
REQ-031 While rst is asserted, strobe outputs SHALL be 0.

Configuration
REQ-032 Macro ADDI_OVF_TRAP_EN: when defined, addi with overflow=1 in WB SHALL write constant 1 to $30 (reg_src=011, reg_dst=10); when undefined, addi SHALL behave exactly as addiu (write ALU result to rt).

Verification
REQ-033 addu, mem_ready=1 throughout -> states 0,1,2,4,0; reg_write high one cycle in WB with reg_dst=01, alu_ctl=00.
REQ-034 lw with mem_ready low 3 cycles in MEM -> mem_read held 4 cycles, then WB with reg_src=001; total 8 cycles.
REQ-035 beq zero=0 -> no pc_write in EXEC; beq zero=1 -> pc_write=1, npc_sel=1; both return to FETCH after 3 cycles.
REQ-036 TIMEOUT=15, mem_ready stuck 0 in FETCH -> HALT after counter reaches 15, err=1; rst=1 returns state=0, err=0.
REQ-037 addi 7FFFFFFFh+1 (overflow=1) -> with ADDI_OVF_TRAP_EN: WB writes 1 to $30; without it: WB writes to rt with reg_src=000.
REQ-038 opcode 3Fh -> DECODE to HALT, err=1, no further strobes.
